result_bus_arbiter: RTL and testbench

//  Shares one 64-bit result bus between four producers (ALU, MUL, LD, BR units).
//  - Picks one valid producer per cycle, round-robin.
//  - Drives select/invSelect of the 64-bit 4:1 NAND mux that steers data.
//  - Registers the winner's data and tag onto the bus, with downstream back-pressure.
//  - Sits between the execute units and the writeback/forwarding stage.

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_pick4.sv | 34 +++
 rtl/result_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_result_bus_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the result bus arbiter.
// Contents: requester count, select width, index type, bus state, mux decode.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] req_idx_t;

    typedef enum logic {
        EMPTY,
        FULL
    } bus_state_t;

    // First rank of the NAND mux: each input's enable is the AND of the
    // true or complement rail of every select bit, so both rails of the
    // select pair are consumed exactly as the physical mux wires them.
    function automatic logic [NREQ-1:0] sel_decode(
        input req_idx_t s,
        input req_idx_t ns
    );
        logic [NREQ-1:0] d;
        d[0] = ns[1] & ns[0];
        d[1] = ns[1] & s[0];
        d[2] = s[1]  & ns[0];
        d[3] = s[1]  & s[0];
        return d;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters.
// Ports: valid (requests), ptr (search start) -> onehot, idx (winner), any.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] onehot,
    output req_idx_t        idx,
    output logic            any
);

    req_idx_t cand;

    // Walk ptr, ptr+1, ... wrapping through the 2-bit index; the first
    // valid candidate wins.
    always_comb begin
        onehot = '0;
        idx    = ptr;
        any    = 1'b0;
        cand   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + req_idx_t'(k);
            if (!any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Shares one registered result bus between the ALU, MUL, LD and BR units.
// Ports: clk, reset (async high), req_valid/req_data/req_tag in, req_ready
// out (one-hot grant), select/invSelect (NAND mux control), bus_valid/
// bus_data/bus_tag out, bus_stall in (consumer back-pressure).
module result_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAGW  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0] req_data,
    input  logic [NREQ-1:0][TAGW-1:0]  req_tag,
    output logic [NREQ-1:0]            req_ready,
    output logic [SEL_W-1:0]           select,
    output logic [SEL_W-1:0]           invSelect,
    output logic                       bus_valid,
    output logic [WIDTH-1:0]           bus_data,
    output logic [TAGW-1:0]            bus_tag,
    input  logic                       bus_stall
);

    bus_state_t state_q;
    bus_state_t state_d;

    req_idx_t ptr_q;
    req_idx_t sel_q;

    logic [NREQ-1:0] pick_onehot;
    req_idx_t        pick_idx;
    logic            pick_any;

    logic load;
    logic grant;

    logic [NREQ-1:0]            dec;
    logic [NREQ-1:0][WIDTH-1:0] nand1;
    logic [WIDTH-1:0]           acc;
    logic [WIDTH-1:0]           mux_data;
    logic [TAGW-1:0]            mux_tag;

    rr_pick4 u_pick (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign bus_valid = (state_q == FULL);

    // The output register may load when empty or when its current
    // content leaves this cycle, which keeps stall release bubble-free.
    assign load = !bus_valid || !bus_stall;

    // Reset also gates the grant so req_ready drops the moment reset
    // rises, not at the next edge.
    assign grant = load && pick_any && !reset;

    assign req_ready = grant ? pick_onehot : '0;

    // Select follows the winner only in grant cycles so the mux does
    // not toggle while the bus is idle or stalled.
    assign select    = grant ? pick_idx : sel_q;
    assign invSelect = ~select;

    // NAND-NAND 4:1 mux: rank one gates each input with its decoded
    // enable, rank two NANDs the four gated terms back together.
    always_comb begin
        dec      = sel_decode(select, invSelect);
        nand1    = '0;
        acc      = '1;
        for (int i = 0; i < NREQ; i++) begin
            nand1[i] = ~(req_data[i] & {WIDTH{dec[i]}});
            acc      = acc & nand1[i];
        end
        mux_data = ~acc;
    end

    assign mux_tag = req_tag[select];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (grant) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!grant && !bus_stall) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            sel_q    <= '0;
            bus_data <= '0;
            bus_tag  <= '0;
        end else if (grant) begin
            ptr_q    <= req_idx_t'(pick_idx + req_idx_t'(1));
            sel_q    <= pick_idx;
            bus_data <= mux_data;
            bus_tag  <= mux_tag;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter.
// Reference model with a scoreboard queue of expected bus results.
module tb_result_bus_arbiter;

    localparam int W = 64;
    localparam int T = 6;

    logic                 clk;
    logic                 reset;
    logic [3:0]           req_valid;
    logic [3:0][W-1:0]    req_data;
    logic [3:0][T-1:0]    req_tag;
    logic [3:0]           req_ready;
    logic [1:0]           select;
    logic [1:0]           invSelect;
    logic                 bus_valid;
    logic [W-1:0]         bus_data;
    logic [T-1:0]         bus_tag;
    logic                 bus_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [T-1:0] t;
    } item_t;

    item_t sb[$];

    int         m_ptr;
    bit         m_full;
    logic [1:0] m_sel;
    int         m_win;

    result_bus_arbiter #(.WIDTH(W), .TAGW(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .select    (select),
        .invSelect (invSelect),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_tag   (bus_tag),
        .bus_stall (bus_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 4; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (reset)
            (req_valid[g] && !req_ready[g]) |=> req_valid[g])
        else begin
            errors++;
            $display("FAIL protocol req %0d dropped without grant", g);
        end
    end

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int w);
        logic [3:0] r;
        r = 4'b0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_sel  = 2'b00;
        m_win  = -1;
        sb.delete();
    endtask

    task automatic predict();
        bit ld;
        ld = !m_full || !bus_stall;
        if (ld && !reset) m_win = pick(req_valid, m_ptr);
        else m_win = -1;
    endtask

    task automatic advance();
        item_t it;
        bit    was_full;
        was_full = m_full;
        @(posedge clk);
        if (was_full && !bus_stall && sb.size() != 0) void'(sb.pop_front());
        if (m_win >= 0) begin
            it.d   = req_data[m_win];
            it.t   = req_tag[m_win];
            sb.push_back(it);
            m_sel  = 2'(m_win);
            m_ptr  = (m_win + 1) % 4;
            m_full = 1'b1;
        end else if (!bus_stall) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        bus_stall = 1'b0;
        for (int n = 0; n < 40 && (req_valid != 0 || m_full); n++) begin
            #1;
            predict();
            advance();
            if (m_win >= 0) req_valid[m_win] = 1'b0;
        end
        checks++;
        if (req_valid != 0 || m_full) begin
            errors++;
            $display("FAIL drain_timeout valid=%b full=%0d", req_valid, m_full);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] b;
        reset     = 1'b1;
        bus_stall = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        req_tag   = '0;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_ready got %b want 0000", req_ready);
        end
        checks++;
        if (bus_valid !== 1'b0 || select !== 2'b00 || invSelect !== 2'b11) begin
            errors++;
            $display("FAIL rst_state got v=%b s=%b is=%b want 0 00 11",
                     bus_valid, select, invSelect);
        end
        req_valid = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        req_valid   = 4'b0001;
        req_data[0] = 64'h1111_2222_3333_4444;
        req_tag[0]  = 6'd1;
        #1;
        predict();
        advance();
        req_valid = 4'b0000;
        checks++;
        if (bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid got %b want 1", bus_valid);
        end

        b           = 64'hABCD_0000_1234_5678;
        req_valid   = 4'b0100;
        req_data[2] = b;
        req_tag[2]  = 6'd2;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || select !== 2'b00 || invSelect !== 2'b11
            || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async got v=%b s=%b is=%b r=%b want 0 00 11 0000",
                     bus_valid, select, invSelect, req_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b0100 || select !== 2'b10) begin
            errors++;
            $display("FAIL rst_after_grant got r=%b s=%b want 0100 10",
                     req_ready, select);
        end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== b || bus_tag !== 6'd2) begin
            errors++;
            $display("FAIL rst_after_bus got %b %h %0d want 1 %h 2",
                     bus_valid, bus_data, bus_tag, b);
        end
        drain();
    endtask

    task automatic test_single();
        do_reset();
        req_valid   = 4'b0001;
        req_data[0] = 64'hDEAD_BEEF_0000_0001;
        req_tag[0]  = 6'd5;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b want 0001", req_ready);
        end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 64'hDEAD_BEEF_0000_0001
            || bus_tag !== 6'd5) begin
            errors++;
            $display("FAIL single_bus got %b %h %0d want 1 deadbeef00000001 5",
                     bus_valid, bus_data, bus_tag);
        end
        #1;
        predict();
        advance();
        checks++;
        if (bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty got %b want 0", bus_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++) begin
                req_data[r] = {$urandom, $urandom};
                req_tag[r]  = 6'($urandom);
            end
            e = 2'(i % 4);
            #1;
            predict();
            checks++;
            if (req_ready !== exp_ready(i % 4)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b",
                         i, req_ready, exp_ready(i % 4));
            end
            checks++;
            if (select !== e || invSelect !== ~e) begin
                errors++;
                $display("FAIL rr_sel%0d got %b/%b want %b/%b",
                         i, select, invSelect, e, ~e);
            end
            advance();
            checks++;
            if (bus_valid !== 1'b1 || sb.size() == 0
                || bus_data !== sb[0].d || bus_tag !== sb[0].t) begin
                errors++;
                $display("FAIL rr_bus%0d got %b %h %0d", i, bus_valid,
                         bus_data, bus_tag);
            end
        end
        drain();
    endtask

    task automatic test_stall();
        logic [W-1:0] h;
        h           = 64'h0123_4567_89AB_CDEF;
        req_valid   = 4'b0001;
        req_data[0] = h;
        req_tag[0]  = 6'd9;
        #1;
        predict();
        advance();
        req_valid   = 4'b0110;
        req_data[1] = 64'h1;
        req_tag[1]  = 6'd11;
        req_data[2] = 64'h2;
        req_tag[2]  = 6'd12;
        bus_stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            predict();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready%0d got %b want 0000", i, req_ready);
            end
            advance();
            checks++;
            if (bus_valid !== 1'b1 || bus_data !== h || bus_tag !== 6'd9) begin
                errors++;
                $display("FAIL stall_hold%0d got %b %h %0d want 1 %h 9",
                         i, bus_valid, bus_data, bus_tag, h);
            end
        end
        bus_stall = 1'b0;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_rel1 got %b want 0010", req_ready);
        end
        advance();
        req_valid[1] = 1'b0;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_rel2 got %b want 0100", req_ready);
        end
        advance();
        req_valid[2] = 1'b0;
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 64'h2 || bus_tag !== 6'd12) begin
            errors++;
            $display("FAIL stall_rel_bus got %b %h %0d want 1 2 12",
                     bus_valid, bus_data, bus_tag);
        end
        drain();
    endtask

    task automatic test_wrap();
        req_valid   = 4'b1000;
        req_data[3] = 64'h33;
        req_tag[3]  = 6'd3;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_g3 got %b want 1000", req_ready);
        end
        advance();
        req_valid   = 4'b1001;
        req_data[0] = 64'h44;
        req_data[3] = 64'h55;
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_g0 got %b want 0001", req_ready);
        end
        advance();
        req_valid[0] = 1'b0;
        checks++;
        if (bus_data !== 64'h44) begin
            errors++;
            $display("FAIL wrap_bus0 got %h want 44", bus_data);
        end
        #1;
        predict();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_g3b got %b want 1000", req_ready);
        end
        advance();
        req_valid[3] = 1'b0;
        checks++;
        if (bus_data !== 64'h55) begin
            errors++;
            $display("FAIL wrap_bus3 got %h want 55", bus_data);
        end
        drain();
    endtask

    task automatic test_random();
        int tx;
        int rx;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 10040; cyc++) begin
            if (cyc < 10000) begin
                bus_stall = ($urandom_range(0, 3) == 0);
                for (int r = 0; r < 4; r++) begin
                    if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                        req_valid[r] = 1'b1;
                        req_data[r]  = {$urandom, $urandom};
                        req_tag[r]   = 6'($urandom);
                    end
                end
            end else begin
                bus_stall = 1'b0;
            end
            #1;
            predict();
            if (bus_valid && !bus_stall) rx++;
            checks++;
            if (req_ready !== exp_ready(m_win)) begin
                errors++;
                $display("FAIL rnd_ready c%0d got %b want %b",
                         cyc, req_ready, exp_ready(m_win));
            end
            advance();
            if (m_win >= 0) begin
                req_valid[m_win] = 1'b0;
                tx++;
            end
            checks++;
            if (bus_valid !== m_full) begin
                errors++;
                $display("FAIL rnd_valid c%0d got %b want %b",
                         cyc, bus_valid, m_full);
            end else if (m_full && sb.size() != 0) begin
                checks++;
                if (bus_data !== sb[0].d || bus_tag !== sb[0].t) begin
                    errors++;
                    $display("FAIL rnd_data c%0d got %h/%0d want %h/%0d",
                             cyc, bus_data, bus_tag, sb[0].d, sb[0].t);
                end
            end
        end
        checks++;
        if (rx !== tx) begin
            errors++;
            $display("FAIL rnd_count got %0d delivered want %0d", rx, tx);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
